// File: rtl/ibex_rf_wseq_pkg.sv
// ibex_rf_wseq_pkg: shared state type and register-file geometry helpers for the write sequencer.
package ibex_rf_wseq_pkg;
  typedef enum logic {RfWseqInit, RfWseqRun} rf_wseq_state_e;
  localparam int unsigned RfPortAddrW = 5;
  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction
  function automatic int unsigned rf_num_words(input bit rv32e);
    return 1 << rf_addr_width(rv32e);
  endfunction
endpackage

// File: rtl/ibex_rf_wseq_fifo.sv
// ibex_rf_wseq_fifo: circular load-write buffer with kill-by-address and a pending-register mask.
module ibex_rf_wseq_fifo import ibex_rf_wseq_pkg::*; #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned NumWords  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [RfPortAddrW-1:0] push_addr_i,
  input  logic [DataWidth-1:0]   push_data_i,
  input  logic                   pop_i,
  input  logic                   kill_i,
  input  logic [RfPortAddrW-1:0] kill_addr_i,
  output logic                   full_o,
  output logic                   head_valid_o,
  output logic                   head_live_o,
  output logic [RfPortAddrW-1:0] head_addr_o,
  output logic [DataWidth-1:0]   head_data_o,
  output logic [NumWords-1:0]    pending_o
);
  typedef struct packed {
    logic                   live;
    logic [RfPortAddrW-1:0] addr;
    logic [DataWidth-1:0]   data;
  } rf_wseq_entry_t;
  localparam int unsigned PtrW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  rf_wseq_entry_t mem_q [FifoDepth];
  rf_wseq_entry_t mem_d [FifoDepth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] cnt_q;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction
  // Popped slots lose their live bit, so live alone marks occupied, non-killed entries.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < FifoDepth; i++)
      if (kill_i && mem_q[i].addr[AddrWidth-1:0] == kill_addr_i[AddrWidth-1:0]) mem_d[i].live = 1'b0;
    if (pop_i) mem_d[rptr_q].live = 1'b0;
    if (push_i) mem_d[wptr_q] = '{live: !(kill_i && push_addr_i[AddrWidth-1:0] == kill_addr_i[AddrWidth-1:0]),
                                  addr: push_addr_i, data: push_data_i};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= pop_i ? inc(rptr_q) : rptr_q;
      wptr_q <= push_i ? inc(wptr_q) : wptr_q;
      cnt_q  <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FifoDepth; i++)
      if (mem_q[i].live) pending_o[mem_q[i].addr[AddrWidth-1:0]] = 1'b1;
  end
  assign full_o       = cnt_q == CntW'(FifoDepth);
  assign head_valid_o = cnt_q != '0;
  assign head_live_o  = mem_q[rptr_q].live;
  assign head_addr_o  = mem_q[rptr_q].addr;
  assign head_data_o  = mem_q[rptr_q].data;
endmodule

// File: rtl/ibex_rf_write_sequencer.sv
// ibex_rf_write_sequencer: sole driver of the FF register-file write port, merging wb and queued lsu writes.
// Define IBEX_RF_WSEQ_INIT_EN to sweep every register to WordZeroVal after reset.
module ibex_rf_write_sequencer import ibex_rf_wseq_pkg::*; #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          FifoDepth   = 2,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wb_valid_i,
  input  logic [4:0]                          wb_addr_i,
  input  logic [DataWidth-1:0]                wb_data_i,
  input  logic                                lsu_valid_i,
  output logic                                lsu_ready_o,
  input  logic [4:0]                          lsu_addr_i,
  input  logic [DataWidth-1:0]                lsu_data_i,
  output logic [4:0]                          rf_waddr_o,
  output logic [DataWidth-1:0]                rf_wdata_o,
  output logic                                rf_we_o,
  output logic [rf_num_words(RV32E)-1:0]      pending_o,
  output logic                                init_done_o,
  output logic                                err_o
);
  localparam int unsigned AW = rf_addr_width(RV32E);
  localparam int unsigned NW = rf_num_words(RV32E);
  logic run, full, head_valid, head_live;
  logic wb_hi, lsu_hi, wb_sel, pop, push, lsu_hs, we_d, we_q, err_d, err_q;
  logic [4:0] head_addr, waddr_d, waddr_q;
  logic [DataWidth-1:0] head_data, wdata_d, wdata_q;
`ifdef IBEX_RF_WSEQ_INIT_EN
  rf_wseq_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  assign run = state_q == RfWseqRun;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!run) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(NW - 1)) state_d = RfWseqRun;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RfWseqInit;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
`else
  logic unused_word_zero;
  assign unused_word_zero = ^WordZeroVal;
  assign run = 1'b1;
`endif
  assign wb_hi       = RV32E && wb_addr_i[4];
  assign lsu_hi      = RV32E && lsu_addr_i[4];
  assign lsu_ready_o = run && !full && !rst_i;
  assign lsu_hs      = lsu_valid_i && lsu_ready_o;
  assign push        = lsu_hs && !lsu_hi && lsu_addr_i[AW-1:0] != '0;
  assign wb_sel      = run && wb_valid_i && !wb_hi && wb_addr_i[AW-1:0] != '0;
  // Any wb request, even to x0, owns the cycle's write slot.
  assign pop         = run && !wb_valid_i && head_valid;
  assign err_d       = err_q || (wb_valid_i && (!run || wb_hi)) || (lsu_hs && lsu_hi);
  always_comb begin
    we_d    = wb_sel || (pop && head_live);
    waddr_d = wb_sel ? wb_addr_i : head_addr;
    wdata_d = wb_sel ? wb_data_i : head_data;
`ifdef IBEX_RF_WSEQ_INIT_EN
    if (!run) begin
      we_d    = 1'b1;
      waddr_d = 5'(idx_q);
      wdata_d = WordZeroVal;
    end
`endif
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  ibex_rf_wseq_fifo #(
    .DataWidth(DataWidth),
    .FifoDepth(FifoDepth),
    .AddrWidth(AW),
    .NumWords (NW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_addr_i (lsu_addr_i),
    .push_data_i (lsu_data_i),
    .pop_i       (pop),
    .kill_i      (wb_sel),
    .kill_addr_i (wb_addr_i),
    .full_o      (full),
    .head_valid_o(head_valid),
    .head_live_o (head_live),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .pending_o   (pending_o)
  );
  assign rf_we_o     = we_q;
  assign rf_waddr_o  = waddr_q;
  assign rf_wdata_o  = wdata_q;
  assign err_o       = err_q;
  assign init_done_o = run;
endmodule
